// File: rtl/axil_uart_regs.sv
// -----------------------------------------------------------------------------
// axil_uart_regs -- AXI4-Lite UART register window with RX/TX byte FIFOs.
//
// Register map (address bits [3:2]):
//   0x0 RX   read pops the RX FIFO, returns {24'b0, byte} or 0 when empty
//   0x4 TX   write pushes WDATA[7:0] when WSTRB[0]; dropped when full
//   0x8 STAT {ovr.., see below}; a read clears bits 7:5
//   0xC CTRL bit0 TX FIFO reset, bit1 RX FIFO reset, bit4 interrupt enable
// STAT: [0] RX valid [1] RX full [2] TX empty [3] TX full [4] int enable
//       [5] overrun  [6] frame error  [7] parity error
//
// Ports:
//   CLK, RST                      clock, synchronous active-high reset
//   AR*/R*, AW*/W*/B*             AXI4-Lite responder channels
//   TX_DATA/TX_VALID/TX_READY     byte stream towards the serializer
//   RX_DATA/RX_VALID/RX_FERR/PERR byte strobe from the deserializer
//   INTR                          one-cycle interrupt pulse (UART_INTR_EN only)
//
// Build option: define UART_INTR_EN to add the INTR port, STAT bit4 and
// CTRL bit4. Without it those bits read 0 / are ignored.
// -----------------------------------------------------------------------------

// Byte FIFO with wrap-bit pointers; clear wins over push/pop.
module axil_uart_fifo #(
   parameter int DEPTH = 16
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       clr_i,
   input  logic       push_i,
   input  logic       pop_i,
   input  logic [7:0] data_i,
   output logic [7:0] data_o,
   output logic       empty_o,
   output logic       full_o,
   output logic       empty_nx_o,
   output logic       full_nx_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [7:0]    mem_q [DEPTH];
   logic          push_ok, pop_ok;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop_ok  = pop_i && !empty_o;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push_ok = push_i && (!full_o || pop_ok);

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (clr_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      end
   end

   assign empty_nx_o = (wr_ptr_d == rd_ptr_d);
   assign full_nx_o  = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                       (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // NOTE: storage is not reset; the pointers alone define which entries are valid.
   always_ff @(posedge CLK) begin
      if (push_ok && !clr_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
   end

   assign data_o = mem_q[rd_ptr_q[AW-1:0]];
endmodule

module axil_uart_regs #(
   parameter int FIFO_DEPTH = 16
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [3:0]  ARADDR,
   input  logic        ARVALID,
   output logic        ARREADY,
   output logic [31:0] RDATA,
   output logic [1:0]  RRESP,
   output logic        RVALID,
   input  logic        RREADY,
   input  logic [3:0]  AWADDR,
   input  logic        AWVALID,
   output logic        AWREADY,
   input  logic [31:0] WDATA,
   input  logic [3:0]  WSTRB,
   input  logic        WVALID,
   output logic        WREADY,
   output logic [1:0]  BRESP,
   output logic        BVALID,
   input  logic        BREADY,
`ifdef UART_INTR_EN
   output logic        INTR,
`endif
   output logic [7:0]  TX_DATA,
   output logic        TX_VALID,
   input  logic        TX_READY,
   input  logic [7:0]  RX_DATA,
   input  logic        RX_VALID,
   input  logic        RX_FERR,
   input  logic        RX_PERR
);
   typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} wr_state_e;
   typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} rd_state_e;

   wr_state_e   wr_state_q, wr_state_d;
   rd_state_e   rd_state_q, rd_state_d;
   logic [31:0] rdata_q, rdata_d, stat_val;
   logic        ovr_q, ovr_d, ferr_q, ferr_d, perr_q, perr_d;
   logic        ovr_set, ferr_set, perr_set;
   logic        wr_fire, rd_fire, ctrl_wr, stat_clr, ien_bit;
   logic        tx_push, tx_pop, tx_clr, rx_pop, rx_clr;
   logic        tx_empty, tx_full_unused, tx_empty_nx, tx_full_nx;
   logic        rx_empty, rx_full, rx_empty_nx, rx_full_nx;
   logic [7:0]  tx_head, rx_head;
   logic        unused_ok;

   assign unused_ok = ^{WDATA, WSTRB[3:1], ARADDR[1:0], AWADDR[1:0]};

   // Write channel: AW and W are only ever accepted together.
   always_comb begin
      wr_state_d = wr_state_q;
      AWREADY    = 1'b0;
      WREADY     = 1'b0;
      BVALID     = 1'b0;
      case (wr_state_q)
         W_IDLE: if (AWVALID && WVALID) wr_state_d = W_ACK;
         W_ACK: begin
            AWREADY    = 1'b1;
            WREADY     = 1'b1;
            wr_state_d = W_RESP;
         end
         W_RESP: begin
            BVALID = 1'b1;
            if (BREADY) wr_state_d = W_IDLE;
         end
         default: wr_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      rd_state_d = rd_state_q;
      ARREADY    = 1'b0;
      RVALID     = 1'b0;
      case (rd_state_q)
         R_IDLE: if (ARVALID) rd_state_d = R_ACK;
         R_ACK: begin
            ARREADY    = 1'b1;
            rd_state_d = R_DATA;
         end
         R_DATA: begin
            RVALID = 1'b1;
            if (RREADY) rd_state_d = R_IDLE;
         end
         default: rd_state_d = R_IDLE;
      endcase
   end

   // Side effects happen on the handshake edge; the master still holds
   // address and data stable there, so no capture registers are needed.
   assign wr_fire  = (wr_state_q == W_ACK);
   assign rd_fire  = (rd_state_q == R_ACK);
   assign ctrl_wr  = wr_fire && (AWADDR[3:2] == 2'd3);
   assign tx_push  = wr_fire && (AWADDR[3:2] == 2'd1) && WSTRB[0];
   assign tx_clr   = ctrl_wr && WDATA[0];
   assign rx_clr   = ctrl_wr && WDATA[1];
   assign rx_pop   = rd_fire && (ARADDR[3:2] == 2'd0);
   assign stat_clr = rd_fire && (ARADDR[3:2] == 2'd2);
   assign tx_pop   = TX_VALID && TX_READY;

   axil_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .CLK(CLK), .RST(RST), .clr_i(tx_clr), .push_i(tx_push), .pop_i(tx_pop),
      .data_i(WDATA[7:0]), .data_o(tx_head), .empty_o(tx_empty),
      .full_o(tx_full_unused), .empty_nx_o(tx_empty_nx), .full_nx_o(tx_full_nx));

   axil_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .CLK(CLK), .RST(RST), .clr_i(rx_clr), .push_i(RX_VALID), .pop_i(rx_pop),
      .data_i(RX_DATA), .data_o(rx_head), .empty_o(rx_empty),
      .full_o(rx_full), .empty_nx_o(rx_empty_nx), .full_nx_o(rx_full_nx));

   assign TX_VALID = !tx_empty;
   assign TX_DATA  = tx_empty ? 8'h00 : tx_head;

   // Sticky flags including this cycle's events; a STAT read returns them
   // and then clears them.
   assign ovr_set  = ovr_q  || (RX_VALID && rx_full && !rx_pop && !rx_clr);
   assign ferr_set = ferr_q || (RX_VALID && RX_FERR);
   assign perr_set = perr_q || (RX_VALID && RX_PERR);
   assign ovr_d    = ovr_set  && !stat_clr;
   assign ferr_d   = ferr_set && !stat_clr;
   assign perr_d   = perr_set && !stat_clr;

   // FIFO bits use next-state pointers so a same-edge push is visible.
   assign stat_val = {24'b0, perr_set, ferr_set, ovr_set, ien_bit,
                      tx_full_nx, tx_empty_nx, rx_full_nx, !rx_empty_nx};

   always_comb begin
      rdata_d = rdata_q;
      if (rd_fire) begin
         case (ARADDR[3:2])
            2'd0:    rdata_d = rx_empty ? 32'h0 : {24'b0, rx_head};
            2'd2:    rdata_d = stat_val;
            default: rdata_d = 32'h0;
         endcase
      end else if ((rd_state_q == R_DATA) && RREADY) begin
         rdata_d = 32'h0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_state_q <= W_IDLE;
         rd_state_q <= R_IDLE;
         rdata_q    <= '0;
         ovr_q      <= 1'b0;
         ferr_q     <= 1'b0;
         perr_q     <= 1'b0;
      end else begin
         wr_state_q <= wr_state_d;
         rd_state_q <= rd_state_d;
         rdata_q    <= rdata_d;
         ovr_q      <= ovr_d;
         ferr_q     <= ferr_d;
         perr_q     <= perr_d;
      end
   end

   assign RDATA = rdata_q;
   assign RRESP = 2'b00;
   assign BRESP = 2'b00;

`ifdef UART_INTR_EN
   logic ien_q, intr_q, rx_was_empty_q, tx_was_empty_q;

   // Edge detectors compare the current FIFO state with last cycle's, so the
   // pulse appears one cycle after the edge that caused the transition.
   always_ff @(posedge CLK) begin
      if (RST) begin
         ien_q          <= 1'b0;
         intr_q         <= 1'b0;
         rx_was_empty_q <= 1'b1;
         tx_was_empty_q <= 1'b1;
      end else begin
         if (ctrl_wr) ien_q <= WDATA[4];
         intr_q         <= ien_q && ((rx_was_empty_q && !rx_empty) ||
                                     (!tx_was_empty_q && tx_empty));
         rx_was_empty_q <= rx_empty;
         tx_was_empty_q <= tx_empty;
      end
   end

   assign INTR    = intr_q;
   assign ien_bit = ien_q;
`else
   assign ien_bit = 1'b0;
`endif
endmodule

// File: tb/tb_axil_uart_regs.sv
// -----------------------------------------------------------------------------
// tb_axil_uart_regs -- directed bench for axil_uart_regs. Stimulus tasks queue
// the expected R, B and TX responses; a monitor on the falling edge pops and
// compares them whenever the DUT completes a handshake.
// -----------------------------------------------------------------------------
module tb_axil_uart_regs;
   logic        CLK = 1'b0;
   logic        RST;
   logic [3:0]  ARADDR, AWADDR;
   logic        ARVALID, ARREADY, RVALID, RREADY;
   logic [31:0] RDATA, WDATA;
   logic [1:0]  RRESP, BRESP;
   logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
   logic [3:0]  WSTRB;
   logic [7:0]  TX_DATA, RX_DATA;
   logic        TX_VALID, TX_READY, RX_VALID, RX_FERR, RX_PERR;
`ifdef UART_INTR_EN
   logic        INTR;
`endif

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] exp_r [$];
   logic [1:0]  exp_b [$];
   logic [7:0]  exp_tx [$];

   always #5 CLK = ~CLK;

   axil_uart_regs #(.FIFO_DEPTH(16)) dut (
      .CLK(CLK), .RST(RST),
      .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
      .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
`ifdef UART_INTR_EN
      .INTR(INTR),
`endif
      .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
      .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_FERR(RX_FERR), .RX_PERR(RX_PERR));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: compares every completed response against the queued model.
   always @(negedge CLK) begin
      if (RVALID && RREADY) begin
         if (exp_r.size() == 0) check("r_unexpected", RDATA, 32'hDEAD_BEEF);
         else begin
            check("rdata", RDATA, exp_r.pop_front());
            check("rresp", {30'b0, RRESP}, 32'h0);
         end
      end
      if (BVALID && BREADY) begin
         if (exp_b.size() == 0) check("b_unexpected", {30'b0, BRESP}, 32'hDEAD_BEEF);
         else check("bresp", {30'b0, BRESP}, {30'b0, exp_b.pop_front()});
      end
      if (TX_VALID && TX_READY) begin
         if (exp_tx.size() == 0) check("tx_unexpected", {24'b0, TX_DATA}, 32'hDEAD_BEEF);
         else check("tx_data", {24'b0, TX_DATA}, {24'b0, exp_tx.pop_front()});
      end
   end

   task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp,
                           input int hold, input bit rx_inj, input logic [7:0] rx_byte);
      bit got = 0;
      exp_r.push_back(exp);
      ARADDR  = addr;
      ARVALID = 1'b1;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge CLK); #1;
         got = ARREADY;
      end
      check("arready_seen", {31'b0, got}, 32'h1);
      if (!got) begin
         ARVALID = 1'b0;
         void'(exp_r.pop_back());
         return;
      end
      // Still before e1: anything driven now lands on the handshake edge.
      if (rx_inj) begin
         RX_DATA  = rx_byte;
         RX_VALID = 1'b1;
      end
      if (hold > 0) RREADY = 1'b0;
      @(posedge CLK); #1;
      ARVALID  = 1'b0;
      RX_VALID = 1'b0;
      for (int i = 0; i < hold; i++) begin
         check("rvalid_held", {31'b0, RVALID}, 32'h1);
         check("rdata_held", RDATA, exp);
         @(posedge CLK); #1;
      end
      RREADY = 1'b1;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge CLK); #1;
         got = !RVALID;
      end
      check("rvalid_dropped", {31'b0, got}, 32'h1);
      check("rdata_cleared", RDATA, 32'h0);
   endtask

   task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int w_delay);
      bit got = 0;
      exp_b.push_back(2'b00);
      AWADDR  = addr;
      WDATA   = data;
      WSTRB   = strb;
      AWVALID = 1'b1;
      // AW alone must never be accepted.
      for (int i = 0; i < w_delay; i++) begin
         @(posedge CLK); #1;
         check("awready_without_w", {31'b0, AWREADY}, 32'h0);
      end
      WVALID = 1'b1;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge CLK); #1;
         got = AWREADY;
      end
      check("awready_seen", {31'b0, got}, 32'h1);
      if (!got) begin
         AWVALID = 1'b0;
         WVALID  = 1'b0;
         void'(exp_b.pop_back());
         return;
      end
      check("wready_with_awready", {31'b0, WREADY}, 32'h1);
      @(posedge CLK); #1;
      AWVALID = 1'b0;
      WVALID  = 1'b0;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge CLK); #1;
         got = !BVALID;
      end
      check("bvalid_dropped", {31'b0, got}, 32'h1);
   endtask

   task automatic rx_strobe(input logic [7:0] b, input logic ferr, input logic perr);
      RX_DATA  = b;
      RX_VALID = 1'b1;
      RX_FERR  = ferr;
      RX_PERR  = perr;
      @(posedge CLK); #1;
      RX_VALID = 1'b0;
      RX_FERR  = 1'b0;
      RX_PERR  = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit done;
      RST = 1'b1;
      ARADDR = '0; ARVALID = 0; RREADY = 1;
      AWADDR = '0; AWVALID = 0; WDATA = '0; WSTRB = '0; WVALID = 0; BREADY = 1;
      TX_READY = 0; RX_DATA = '0; RX_VALID = 0; RX_FERR = 0; RX_PERR = 0;
      repeat (3) @(posedge CLK);
      #1;
      check("rst_arready", {31'b0, ARREADY}, 32'h0);
      check("rst_rvalid",  {31'b0, RVALID},  32'h0);
      check("rst_awready", {31'b0, AWREADY}, 32'h0);
      check("rst_wready",  {31'b0, WREADY},  32'h0);
      check("rst_bvalid",  {31'b0, BVALID},  32'h0);
      check("rst_rdata",   RDATA,            32'h0);
      check("rst_tx_valid", {31'b0, TX_VALID}, 32'h0);
      check("rst_tx_data", {24'b0, TX_DATA}, 32'h0);
`ifdef UART_INTR_EN
      check("rst_intr", {31'b0, INTR}, 32'h0);
`endif
      RST = 1'b0;
      @(posedge CLK); #1;

      // STAT after reset: only TX empty; RVALID held while RREADY is low.
      axi_read(4'h8, 32'h0000_0004, 3, 0, 8'h00);

      // One TX byte parked (serializer stalled).
      axi_write(4'h4, 32'h0000_0041, 4'hF, 0);
      check("tx_valid_parked", {31'b0, TX_VALID}, 32'h1);
      check("tx_data_parked", {24'b0, TX_DATA}, 32'h41);
      axi_read(4'h8, 32'h0000_0000, 0, 0, 8'h00);

      // Fill RX, then overflow with a framing error.
      for (int i = 0; i < 16; i++) rx_strobe(8'(i), 1'b0, 1'b0);
      rx_strobe(8'hEE, 1'b1, 1'b0);
      axi_read(4'h8, 32'h0000_0063, 0, 0, 8'h00);
      axi_read(4'h8, 32'h0000_0003, 0, 0, 8'h00);

      // Push on the same edge a full-FIFO pop handshakes: no overrun.
      axi_read(4'h0, 32'h0000_0000, 0, 1, 8'hA5);
      axi_read(4'h8, 32'h0000_0003, 0, 0, 8'h00);
      for (int i = 1; i < 16; i++) axi_read(4'h0, 32'(i), 0, 0, 8'h00);
      axi_read(4'h0, 32'h0000_00A5, 0, 0, 8'h00);
      axi_read(4'h0, 32'h0000_0000, 0, 0, 8'h00);
      axi_read(4'h8, 32'h0000_0000, 0, 0, 8'h00);

      // Parity error is sticky and cleared by the STAT read.
      rx_strobe(8'h77, 1'b0, 1'b1);
      axi_read(4'h8, 32'h0000_0081, 0, 0, 8'h00);
      axi_read(4'h8, 32'h0000_0001, 0, 0, 8'h00);

      // CTRL resets both FIFOs; TX/CTRL read as zero; STAT writes ignored.
      axi_write(4'hC, 32'h0000_0003, 4'hF, 0);
      axi_read(4'h8, 32'h0000_0004, 0, 0, 8'h00);
      axi_read(4'h4, 32'h0000_0000, 0, 0, 8'h00);
      axi_read(4'hC, 32'h0000_0000, 0, 0, 8'h00);
      axi_write(4'h8, 32'h0000_00FF, 4'hF, 0);
      axi_write(4'h4, 32'h0000_0099, 4'hE, 2);
      axi_read(4'h8, 32'h0000_0004, 0, 0, 8'h00);

      // Single byte straight through to the serializer.
      TX_READY = 1'b1;
      exp_tx.push_back(8'h41);
      axi_write(4'h4, 32'h0000_0041, 4'h1, 0);
      repeat (3) @(posedge CLK);
      #1;
      axi_read(4'h8, 32'h0000_0004, 0, 0, 8'h00);

      // 17 writes into a 16-deep TX FIFO: the last byte is dropped.
      TX_READY = 1'b0;
      for (int i = 0; i < 17; i++) axi_write(4'h4, 32'(i), 4'hF, 0);
      axi_read(4'h8, 32'h0000_0008, 0, 0, 8'h00);
      for (int i = 0; i < 16; i++) exp_tx.push_back(8'(i));
      TX_READY = 1'b1;
      done = 0;
      for (int i = 0; i < 60 && !done; i++) begin
         @(posedge CLK); #1;
         done = (exp_tx.size() == 0) && !TX_VALID;
      end
      check("tx_drain_done", {31'b0, done}, 32'h1);
      repeat (3) @(posedge CLK);
      #1;
      check("tx_valid_after_drain", {31'b0, TX_VALID}, 32'h0);
      axi_read(4'h8, 32'h0000_0004, 0, 0, 8'h00);

`ifdef UART_INTR_EN
      axi_write(4'hC, 32'h0000_0010, 4'hF, 0);
      axi_read(4'h8, 32'h0000_0014, 0, 0, 8'h00);
      rx_strobe(8'h5A, 1'b0, 1'b0);
      check("intr_push_cycle", {31'b0, INTR}, 32'h0);
      @(posedge CLK); #1;
      check("intr_pulse", {31'b0, INTR}, 32'h1);
      @(posedge CLK); #1;
      check("intr_one_cycle", {31'b0, INTR}, 32'h0);
      axi_read(4'h0, 32'h0000_005A, 0, 0, 8'h00);
`else
      axi_write(4'hC, 32'h0000_0010, 4'hF, 0);
      axi_read(4'h8, 32'h0000_0004, 0, 0, 8'h00);
`endif

      // Reset in the middle of a read: no response is produced.
      ARADDR  = 4'h8;
      ARVALID = 1'b1;
      @(posedge CLK); #1;
      check("mid_rst_arready", {31'b0, ARREADY}, 32'h1);
      RST     = 1'b1;
      ARVALID = 1'b0;
      @(posedge CLK); #1;
      check("mid_rst_arready_drop", {31'b0, ARREADY}, 32'h0);
      check("mid_rst_rvalid", {31'b0, RVALID}, 32'h0);
      RST = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      check("mid_rst_no_rvalid", {31'b0, RVALID}, 32'h0);

      check("r_queue_empty",  32'(exp_r.size()),  32'h0);
      check("b_queue_empty",  32'(exp_b.size()),  32'h0);
      check("tx_queue_empty", 32'(exp_tx.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/axil_uart_regs.md
# axil_uart_regs

AXI4-Lite responder that gives the core its UART register window: RX FIFO at 0x0, TX FIFO at 0x4, STAT at 0x8, CTRL at 0xC. It buffers bytes between the core's `in`/`out` bus transactions and the byte-stream side of the serial PHY. The block sits between the core's AR/R/AW/W/B ports and the UART serializer/deserializer.

## Interface
- FIFO_DEPTH, 16, entries per FIFO; must be a power of two ≥ 2.
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  synchronous reset, active-high.
- ARADDR  in  4  read address; bits [3:2] select the register.
- ARVALID  in  1 / ARREADY  out  1  read address handshake.
- RDATA  out  32 / RRESP  out  2 / RVALID  out  1 / RREADY  in  1  read data channel.
- AWADDR  in  4 / AWVALID  in  1 / AWREADY  out  1  write address channel.
- WDATA  in  32 / WSTRB  in  4 / WVALID  in  1 / WREADY  out  1  write data channel.
- BRESP  out  2 / BVALID  out  1 / BREADY  in  1  write response channel.
- TX_DATA  out  8 / TX_VALID  out  1 / TX_READY  in  1  byte stream to the serializer.
- RX_DATA  in  8 / RX_VALID  in  1  one-cycle strobe from the deserializer; no backpressure.
- RX_FERR  in  1 / RX_PERR  in  1  error flags for the strobed RX byte.
- INTR  out  1  interrupt; present only under UART_INTR_EN.

## Operation
- Register map, by ARADDR/AWADDR[3:2]:
  - 0 RX: read pops the RX FIFO. RDATA = {24'b0, byte}. If the FIFO is empty, RDATA = 0 and nothing pops.
  - 1 TX: write pushes WDATA[7:0], but only when WSTRB[0]=1. If the TX FIFO is full, the byte is dropped. Reads return 0.
  - 2 STAT, read-only:
    - bit0 RX valid (RX FIFO not empty)
    - bit1 RX full
    - bit2 TX empty
    - bit3 TX full
    - bit4 interrupt enable
    - bit5 overrun
    - bit6 frame error
    - bit7 parity error
    - bits 31:8 = 0
    - A STAT read clears bits 7:5 on the handshake edge.
  - 3 CTRL, write-only:
    - bit0 resets the TX FIFO.
    - bit1 resets the RX FIFO.
    - bit4 sets the interrupt enable.
    - Reads return 0.
- Writes to RX or STAT are ignored. BRESP and RRESP are always 2'b00 (OKAY).
- RX path:
  - RX_VALID pushes RX_DATA into the RX FIFO.
  - RX_FERR/RX_PERR sticky-set STAT bits 6/7.
  - RX_VALID while the RX FIFO is full sets overrun; the byte is dropped.
  - A push and a pop in the same cycle on a full FIFO is legal and does not set overrun.
- TX path: TX_VALID = TX FIFO not empty; TX_DATA = head entry; the entry pops on TX_VALID & TX_READY.
- FIFOs: log2(FIFO_DEPTH)+1-bit read/write pointers that wrap modulo 2·FIFO_DEPTH. Empty when the pointers are equal; full when they differ only in the MSB.
- The CTRL FIFO reset wins over a simultaneous push or pop to the same FIFO.

## Timing
- Reset values: all READY/VALID outputs 0, RDATA 0, RRESP/BRESP 0, TX_DATA 0, INTR 0, both FIFOs empty, STAT bits 7:4 = 0.
- Write handshake:
  - Edge e0 samples AWVALID & WVALID & !AWREADY & !BVALID. AWREADY and WREADY are then 1 for exactly one cycle.
  - Edge e1 is the handshake edge: the register side effect happens and BVALID rises.
  - BVALID holds until sampled with BREADY; it drops on that edge.
  - AW and W are accepted only together. The block never accepts one channel without the other.
- Read handshake:
  - Edge e0 samples ARVALID & !ARREADY & !RVALID. ARREADY is then 1 for exactly one cycle.
  - Edge e1: RDATA latches, the RX pop or STAT clear happens, and RVALID rises.
  - RDATA/RVALID hold until RREADY; both drop on that edge.
- One outstanding read and one outstanding write. The read and write paths are independent and may overlap.
- STAT reflects FIFO state as of the handshake edge, including any same-edge RX_VALID push.
- RST asserted mid-transaction drops every VALID/READY on the next edge; in-flight transactions are abandoned with no response.

## Configuration
- UART_INTR_EN defined:
  - INTR is a registered one-cycle pulse.
  - It fires when interrupt enable = 1 and either:
    - the RX FIFO transitions empty→non-empty, or
    - the TX FIFO transitions non-empty→empty.
- UART_INTR_EN undefined:
  - The INTR port and its logic are absent.
  - STAT bit4 reads 0 and CTRL bit4 is ignored.

## Test plan
- Reset, then read 0x8 → RDATA=0x00000004 (TX empty), RRESP=0, RVALID held until RREADY.
- Write 0x41 to 0x4 with TX_READY=0 → STAT=0x00000000. Set TX_READY=1 → one TX_DATA=0x41 beat, then STAT=0x00000004.
- Write 17 bytes 0x00..0x10 to TX with TX_READY=0, FIFO_DEPTH=16 → STAT bit3=1, each write gets BRESP=0, the drain yields 0x00..0x0F only.
- Strobe 16 RX bytes, then a 17th with RX_FERR=1 → STAT=0x63. Second STAT read → 0x03. RX reads return bytes in order, then 0 when empty.
- Pulse RX_VALID on the same edge a full-RX read handshakes → no overrun, count stays 16. CTRL write 0x3 → STAT=0x04.
- With UART_INTR_EN: write CTRL 0x10, strobe RX_DATA=0x5A → INTR is high for exactly one cycle, 1 cycle after the push edge.
